mem_writer: RTL and testbench
=============================

# mem_writer

Byte-serial store engine for the CPU's linear memory. It is the write-side counterpart of the ROM fetch port: it takes the same address, extra and wide-data triple that a read returns, checks the range against lower/upper bounds, and drives a byte-wide RAM write port one byte per clock. It sits between the CPU store path and the shared byte RAM, and reports completion or a bounds trap back to the CPU.

## Interface

Parameters:
- `AW`, default 3: the address is `AW+1` bits wide (`[AW:0]`).
- `EXTRA`, default 4: the data window is `2**EXTRA` bytes, so `data` is `2**EXTRA*8` bits wide.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  engine idle; the request is accepted when `req_valid & req_ready`.
- `addr`  in  AW+1  first byte address.
- `extra`  in  EXTRA  byte count minus one (1 to `2**EXTRA` bytes).
- `data`  in  2**EXTRA*8  store payload; byte i is `data[8i+7:8i]`.
- `lower_bound`  in  AW+1  lowest writable address, inclusive.
- `upper_bound`  in  AW+1  highest writable address, inclusive.
- `ram_we`  out  1  RAM byte write strobe.
- `ram_addr`  out  AW+1  RAM byte address.
- `ram_wdata`  out  8  RAM byte data.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  bounds trap; valid only while `done` is high.

## Operation

- FSM states: IDLE, WRITE, DONE.
- **IDLE**
  - `req_ready=1`.
  - On handshake, latch `addr`, `extra`, `data`, `lower_bound` and `upper_bound`.
  - Compute `last = addr + extra` at AW+2 bits, so that a carry out is visible.
- **Range check** (at accept):
  - Fault if `addr < lower_bound`, `last > upper_bound`, or `last` carries past `2**(AW+1)-1`.
  - On fault, go to DONE with `error=1`. No byte is written.
  - A request with no fault goes to WRITE.
- **WRITE**
  - One byte per cycle, byte index i = 0..extra.
  - `ram_we=1`, `ram_addr=addr+i` (never wraps, because the range check guarantees it), `ram_wdata = byte i`.
  - After byte `extra`, go to DONE.
- **DONE**
  - `done=1` for exactly one cycle, then return to IDLE.
  - `error` is 1 for a fault and 0 otherwise.
- Outputs are low (0) outside their defining states: `ram_we`, `done` and `error` are 0 except as stated above. `ram_addr` and `ram_wdata` are don't-care when `ram_we=0`, but the bench expects them to read 0.
- Input changes after accept have no effect, because all request fields are latched.
- `req_ready` is low in WRITE and DONE. A request held across those states is accepted on the first IDLE cycle.

## Timing

- Reset values (applied at the first clock edge with `reset=0`): state IDLE, `req_ready=1`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`, `done=0`, `error=0`.
- Handshake at edge T:
  - First `ram_we` in cycle T+1.
  - Last byte in cycle T+1+extra.
  - `done` in cycle T+2+extra.
  - `req_ready` high again in cycle T+3+extra.
- Fault handshake at edge T: `done=1`, `error=1` in cycle T+1; `req_ready` high again in cycle T+2.
- Back-to-back throughput is one request per `extra+3` cycles.
- Reset asserted mid-WRITE:
  - The next cycle has `ram_we=0` and the state is IDLE.
  - Bytes already written stay written.
  - No `done` is produced.
- `reset` low together with `req_valid` high: the request is dropped, not accepted.

## Configuration

- `MEM_WRITER_BIG_ENDIAN_EN`
  - Undefined (the default): little-endian. Byte i of `data` goes to `addr+i`, which matches the WebAssembly memory byte order.
  - Defined: byte i goes to `addr+extra-i`, i.e. the payload is stored most-significant byte first.
  - Range check, latency and every other behaviour are identical in both builds.

## Test plan

All scenarios use AW=3, EXTRA=4, bounds 0..15 unless stated otherwise.

- **Reset:** `reset` low for 2 cycles → `req_ready=1`, `ram_we=0`, `done=0`, `error=0`.
- **4-byte store:** `addr=4`, `extra=3`, `data=0x2A1B0C7F` → writes 7F@4, 0C@5, 1B@6, 2A@7 on cycles T+1..T+4, then `done=1`, `error=0` at T+5.
- **Single byte at the top:** `addr=15`, `extra=0`, `data=0x42` → one write of 42@15, then `done` at T+2.
- **Bounds fault:**
  - `lower_bound=8`, `addr=6`, `extra=1` → `done=1`, `error=1` at T+1, zero `ram_we` cycles.
  - Separately, `addr=14`, `extra=3` (overflows past 15) → same fault response.
- **Reset mid-WRITE:** `extra=7`, `reset` low after the 3rd byte → only bytes 0..2 are written, no `done`, `req_ready=1` after reset.
- **Big-endian build:** define `MEM_WRITER_BIG_ENDIAN_EN`, then `addr=0`, `extra=1`, `data=0x1234` → 12@0, 34@1.

Source files
------------

// File: rtl/mem_writer_if.sv
// Store-request / byte-RAM bundle shared by the CPU store path and mem_writer.
// master = requester side, slave = the mem_writer engine.
interface mem_writer_if #(
  parameter int AW    = 3,
  parameter int EXTRA = 4
);
  logic                     req_valid;
  logic                     req_ready;
  logic [AW:0]              addr;
  logic [EXTRA-1:0]         extra;
  logic [(2**EXTRA)*8-1:0]  data;
  logic [AW:0]              lower_bound;
  logic [AW:0]              upper_bound;
  logic                     ram_we;
  logic [AW:0]              ram_addr;
  logic [7:0]               ram_wdata;
  logic                     done;
  logic                     error;

  modport master (
    output req_valid, addr, extra, data, lower_bound, upper_bound,
    input  req_ready, ram_we, ram_addr, ram_wdata, done, error
  );

  modport slave (
    input  req_valid, addr, extra, data, lower_bound, upper_bound,
    output req_ready, ram_we, ram_addr, ram_wdata, done, error
  );
endinterface

// File: rtl/mem_writer.sv
// Byte-serial bounds-checked store engine driving a byte-wide RAM write port.
// Build option: define MEM_WRITER_BIG_ENDIAN_EN to store the payload MSB first.
//
// state   | meaning
// S_IDLE  | req_ready high, range check and latch on handshake
// S_WRITE | one RAM byte per cycle, byte index idx_q = 0..extra
// S_DONE  | one-cycle done pulse, error set on a bounds fault
module mem_writer #(
  parameter int AW    = 3,
  parameter int EXTRA = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_writer_if.slave  bus
);

  localparam int ADDR_W = AW + 1;
  localparam int DW     = (2**EXTRA) * 8;
  // Wide enough for the carry of addr+extra whatever the parameter mix.
  localparam int LAST_W = (AW + 2 > EXTRA + 1) ? AW + 2 : EXTRA + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [DW-1:0]     data_q;
  logic [EXTRA-1:0]  extra_q;
  logic [EXTRA-1:0]  idx_q;
  logic              req_ready_q;
  logic              ram_we_q;
  logic [AW:0]       ram_addr_q;
  logic [7:0]        ram_wdata_q;
  logic              done_q;
  logic              error_q;

  logic [LAST_W-1:0] last_d;
  logic              fault_d;
  logic [EXTRA-1:0]  idx_d;
  logic [AW:0]       first_addr_d;
  logic [AW:0]       next_addr_d;

  always_comb begin
    last_d  = LAST_W'(bus.addr) + LAST_W'(bus.extra);
    fault_d = (bus.addr < bus.lower_bound)
           || (last_d > LAST_W'(bus.upper_bound))
           || (|last_d[LAST_W-1:ADDR_W]);
    idx_d   = idx_q + EXTRA'(1);
`ifdef MEM_WRITER_BIG_ENDIAN_EN
    first_addr_d = last_d[AW:0];
    next_addr_d  = ram_addr_q - ADDR_W'(1);
`else
    first_addr_d = bus.addr;
    next_addr_d  = ram_addr_q + ADDR_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      extra_q     <= '0;
      idx_q       <= '0;
      req_ready_q <= 1'b1;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            data_q      <= bus.data;
            extra_q     <= bus.extra;
            idx_q       <= '0;
            req_ready_q <= 1'b0;
            if (fault_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else begin
              state_q     <= S_WRITE;
              ram_we_q    <= 1'b1;
              ram_addr_q  <= first_addr_d;
              ram_wdata_q <= bus.data[7:0];
            end
          end
        end
        S_WRITE: begin
          if (idx_q == extra_q) begin
            state_q     <= S_DONE;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            done_q      <= 1'b1;
          end else begin
            idx_q       <= idx_d;
            ram_addr_q  <= next_addr_d;
            ram_wdata_q <= data_q[{idx_d, 3'b000} +: 8];
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          done_q      <= 1'b0;
          error_q     <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_mem_writer.sv
// Directed bench for mem_writer: vector table plus back-to-back and reset-mid-write sequences.
// Expected RAM addresses follow MEM_WRITER_BIG_ENDIAN_EN when it is defined.
module tb_mem_writer;
  localparam int AW    = 3;
  localparam int EXTRA = 4;
  localparam int DW    = (2**EXTRA) * 8;
  localparam int AWP   = AW + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_writer_if #(.AW(AW), .EXTRA(EXTRA)) bus ();
  mem_writer #(.AW(AW), .EXTRA(EXTRA)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;
  int wr_count = 0;
  int done_count = 0;
  logic [7:0] mem [16];

  always @(negedge clk) begin
    if (bus.ram_we === 1'b1) begin
      mem[bus.ram_addr] = bus.ram_wdata;
      wr_count++;
    end
    if (bus.done === 1'b1) done_count++;
  end

  typedef struct {
    logic [AW:0]      a;
    logic [EXTRA-1:0] e;
    logic [DW-1:0]    d;
    logic [AW:0]      lo;
    logic [AW:0]      hi;
    logic             err;
    int               n;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW:0] exp_addr(input logic [AW:0] a, input logic [EXTRA-1:0] e, input int i);
`ifdef MEM_WRITER_BIG_ENDIAN_EN
    return a + AWP'(e) - AWP'(i);
`else
    return a + AWP'(i);
`endif
  endfunction

  task automatic run_req(input int k, input vec_t v);
    int w0;
    int d0;
    w0 = wr_count;
    d0 = done_count;
    bus.req_valid   = 1'b1;
    bus.addr        = v.a;
    bus.extra       = v.e;
    bus.data        = v.d;
    bus.lower_bound = v.lo;
    bus.upper_bound = v.hi;
    chk($sformatf("v%0d_ready_idle", k), bus.req_ready, 1);
    step();
    // scramble request fields: everything must already be latched
    bus.req_valid = 1'b0;
    bus.addr      = ~v.a;
    bus.extra     = ~v.e;
    bus.data      = ~v.d;
    if (v.err) begin
      chk($sformatf("v%0d_fault_done", k), bus.done, 1);
      chk($sformatf("v%0d_fault_error", k), bus.error, 1);
      chk($sformatf("v%0d_fault_we", k), bus.ram_we, 0);
      step();
    end else begin
      for (int i = 0; i <= int'(v.e); i++) begin
        chk($sformatf("v%0d_we%0d", k, i), bus.ram_we, 1);
        chk($sformatf("v%0d_addr%0d", k, i), bus.ram_addr, exp_addr(v.a, v.e, i));
        chk($sformatf("v%0d_wdata%0d", k, i), bus.ram_wdata, v.d[8*i +: 8]);
        chk($sformatf("v%0d_nodone%0d", k, i), bus.done, 0);
        chk($sformatf("v%0d_busy%0d", k, i), bus.req_ready, 0);
        step();
      end
      chk($sformatf("v%0d_done", k), bus.done, 1);
      chk($sformatf("v%0d_error", k), bus.error, 0);
      chk($sformatf("v%0d_done_we", k), bus.ram_we, 0);
      chk($sformatf("v%0d_done_addr", k), bus.ram_addr, 0);
      chk($sformatf("v%0d_done_wdata", k), bus.ram_wdata, 0);
      step();
    end
    chk($sformatf("v%0d_post_done", k), bus.done, 0);
    chk($sformatf("v%0d_post_error", k), bus.error, 0);
    chk($sformatf("v%0d_post_ready", k), bus.req_ready, 1);
    chk($sformatf("v%0d_nwrites", k), 128'(wr_count - w0), 128'(v.n));
    chk($sformatf("v%0d_ndone", k), 128'(done_count - d0), 1);
  endtask

  initial begin
    logic [7:0] we_pat;
    logic [7:0] done_pat;
    logic [7:0] rdy_pat;
    int w0;
    int d0;

    vecs[0] = '{a: 4'd4,  e: 4'd3,  d: 128'h2A1B0C7F, lo: 4'd0, hi: 4'd15, err: 1'b0, n: 4};
    vecs[1] = '{a: 4'd15, e: 4'd0,  d: 128'h42,       lo: 4'd0, hi: 4'd15, err: 1'b0, n: 1};
    vecs[2] = '{a: 4'd6,  e: 4'd1,  d: 128'hBEEF,     lo: 4'd8, hi: 4'd15, err: 1'b1, n: 0};
    vecs[3] = '{a: 4'd14, e: 4'd3,  d: 128'h11223344, lo: 4'd0, hi: 4'd15, err: 1'b1, n: 0};
    vecs[4] = '{a: 4'd0,  e: 4'd15, d: 128'h00112233445566778899AABBCCDDEEFF,
                lo: 4'd0, hi: 4'd15, err: 1'b0, n: 16};
    vecs[5] = '{a: 4'd10, e: 4'd2,  d: 128'hC3B2A1,   lo: 4'd0, hi: 4'd12, err: 1'b0, n: 3};
    vecs[6] = '{a: 4'd10, e: 4'd3,  d: 128'hD4C3B2A1, lo: 4'd0, hi: 4'd12, err: 1'b1, n: 0};
    vecs[7] = '{a: 4'd8,  e: 4'd0,  d: 128'h5A,       lo: 4'd8, hi: 4'd8,  err: 1'b0, n: 1};
    vecs[8] = '{a: 4'd0,  e: 4'd1,  d: 128'h1234,     lo: 4'd0, hi: 4'd15, err: 1'b0, n: 2};

    reset = 1'b0;
    bus.req_valid = 1'b1;
    bus.addr = '0;
    bus.extra = '0;
    bus.data = '0;
    bus.lower_bound = '0;
    bus.upper_bound = 4'd15;
    repeat (2) step();
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_we", bus.ram_we, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("rst_dropped_we", bus.ram_we, 0);

    for (int k = 0; k < 9; k++) run_req(k, vecs[k]);

    // back-to-back: request held high, one accept every extra+3 cycles
    we_pat   = 8'b11001100;
    done_pat = 8'b00100010;
    rdy_pat  = 8'b00010001;
    bus.req_valid   = 1'b1;
    bus.addr        = 4'd2;
    bus.extra       = 4'd1;
    bus.data        = 128'hBBAA;
    bus.lower_bound = 4'd0;
    bus.upper_bound = 4'd15;
    step();
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("b2b_we%0d", c), bus.ram_we, we_pat[7-c]);
      chk($sformatf("b2b_done%0d", c), bus.done, done_pat[7-c]);
      chk($sformatf("b2b_ready%0d", c), bus.req_ready, rdy_pat[7-c]);
      if (c == 7) bus.req_valid = 1'b0;
      step();
    end
    chk("b2b_idle_we", bus.ram_we, 0);
    chk("b2b_idle_ready", bus.req_ready, 1);

    // reset asserted while the third byte is on the bus
    w0 = wr_count;
    d0 = done_count;
    bus.req_valid = 1'b1;
    bus.addr      = 4'd0;
    bus.extra     = 4'd7;
    bus.data      = 128'h0807060504030201;
    step();
    bus.extra = 4'd0;
    step();
    step();
    chk("rmw_byte2_we", bus.ram_we, 1);
    reset = 1'b0;
    step();
    chk("rmw_we_off", bus.ram_we, 0);
    chk("rmw_no_done", bus.done, 0);
    chk("rmw_ready", bus.req_ready, 1);
    step();
    chk("rmw_held_we", bus.ram_we, 0);
    reset = 1'b1;
    bus.req_valid = 1'b0;
    step();
    step();
    chk("rmw_idle_we", bus.ram_we, 0);
    chk("rmw_nwrites", 128'(wr_count - w0), 3);
    chk("rmw_ndone", 128'(done_count - d0), 0);
    chk("rmw_mem0", mem[exp_addr(4'd0, 4'd7, 0)], 8'h01);
    chk("rmw_mem1", mem[exp_addr(4'd0, 4'd7, 1)], 8'h02);
    chk("rmw_mem2", mem[exp_addr(4'd0, 4'd7, 2)], 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
